// File: rtl/up_count_pkg.sv
// rtl/up_count_pkg.sv - shared state type and default sizing for the up/down counter sequencers
//
// Purpose:
//   Common definitions for the loadable counter sequencer family. The state
//   enum and the default WIDTH/LIMIT values are also used by the down-counter
//   block, so both counters park and size themselves the same way.
//
// Contents:
//   state_e        - PARK (idle, count held at 0) / RUN (counting)
//   DEFAULT_WIDTH  - default counter width
//   DEFAULT_LIMIT  - default highest count value before wrap
package up_count_pkg;

    typedef enum logic {
        PARK = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_LIMIT = 7;

endpackage

// File: rtl/up_count_seq.sv
// rtl/up_count_seq.sv - loadable up-counter sequencer with parked idle state and wrap carry
//
// Purpose:
//   Steps forward through slots 0..LIMIT. After reset it parks with count 0.
//   A load of din <= LIMIT starts it running from din; a load of din > LIMIT
//   is rejected (parks, count 0, one-cycle load_err). While running with en=1
//   it increments, and at LIMIT wraps to 0 with a one-cycle carry.
//   Edge priority: reset > load > en. All outputs are registered.
//
// Build option:
//   UP_COUNT_SEQ_ONESHOT_EN - when defined, the wrap at LIMIT also returns the
//   sequencer to PARK, so it runs once per load. When undefined it wraps and
//   keeps running.
//
// Parameters:
//   WIDTH - width of din and count
//   LIMIT - highest count value, 0 < LIMIT <= 2**WIDTH-1
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   load     in   synchronous load strobe
//   din      in   load value [WIDTH-1:0]
//   en       in   count enable while running
//   count    out  current count [WIDTH-1:0], registered
//   active   out  1 in RUN, 0 in PARK, registered
//   carry    out  one-cycle pulse on LIMIT->0 wrap, registered
//   load_err out  one-cycle pulse when a load of din > LIMIT is rejected
module up_count_seq
    import up_count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LIMIT = DEFAULT_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             carry,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             active_q, active_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            // A load wins over en in the same cycle, from either state.
            if (din <= LIMIT_W) begin
                state_d = RUN;
                count_d = din;
            end else begin
                state_d    = PARK;
                count_d    = '0;
                load_err_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (en) begin
                // The increment is never applied at LIMIT, so the adder
                // cannot overflow even when LIMIT == 2**WIDTH-1.
                if (count_q == LIMIT_W) begin
                    count_d = '0;
                    carry_d = 1'b1;
`ifdef UP_COUNT_SEQ_ONESHOT_EN
                    state_d = PARK;
`else
                    state_d = RUN;
`endif
                end else begin
                    count_d = count_q + ONE_W;
                end
            end
        end else begin
            // Parked: en is ignored and count is held at 0.
            count_d = '0;
        end

        // active tracks the next state so it is registered alongside it.
        active_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PARK;
            count_q    <= '0;
            active_q   <= 1'b0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            active_q   <= active_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign active   = active_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_up_count_seq.sv
// tb/tb_up_count_seq.sv - scoreboard bench for up_count_seq (LIMIT=7 and LIMIT=5 instances)
module tb_up_count_seq;

`ifdef UP_COUNT_SEQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef struct {
        bit         sel;
        logic [2:0] count;
        logic       active;
        logic       carry;
        logic       load_err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_load, a_en, b_load, b_en;
    logic [2:0] a_din, b_din;
    logic [2:0] a_count, b_count;
    logic       a_active, a_carry, a_load_err;
    logic       b_active, b_carry, b_load_err;

    int tests  = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    up_count_seq #(.WIDTH(3), .LIMIT(7)) dut_a (
        .clk(clk), .reset(reset), .load(a_load), .din(a_din), .en(a_en),
        .count(a_count), .active(a_active), .carry(a_carry), .load_err(a_load_err)
    );

    up_count_seq #(.WIDTH(3), .LIMIT(5)) dut_b (
        .clk(clk), .reset(reset), .load(b_load), .din(b_din), .en(b_en),
        .count(b_count), .active(b_active), .carry(b_carry), .load_err(b_load_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the design produces a result every cycle; each negedge with a
    // pending expectation pops it and compares against the selected instance.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (!e.sel) begin
                chk("a_count",    32'(a_count),    32'(e.count));
                chk("a_active",   32'(a_active),   32'(e.active));
                chk("a_carry",    32'(a_carry),    32'(e.carry));
                chk("a_load_err", 32'(a_load_err), 32'(e.load_err));
            end else begin
                chk("b_count",    32'(b_count),    32'(e.count));
                chk("b_active",   32'(b_active),   32'(e.active));
                chk("b_carry",    32'(b_carry),    32'(e.carry));
                chk("b_load_err", 32'(b_load_err), 32'(e.load_err));
            end
        end
    end

    // Drive one cycle of inputs on the selected instance and queue the
    // hand-computed state expected after the following rising edge.
    task automatic step(input bit sel, input bit l, input logic [2:0] d, input bit e,
                        input logic [2:0] c, input bit act, input bit cy, input bit er);
        exp_t x;
        @(negedge clk);
        a_load = 1'b0; a_en = 1'b0; b_load = 1'b0; b_en = 1'b0;
        if (!sel) begin
            a_load = l; a_din = d; a_en = e;
        end else begin
            b_load = l; b_din = d; b_en = e;
        end
        @(posedge clk);
        #1;
        x.sel = sel; x.count = c; x.active = act; x.carry = cy; x.load_err = er;
        sb_q.push_back(x);
    endtask

    initial begin
        reset  = 1'b1;
        a_load = 1'b0; a_din = 3'd0; a_en = 1'b0;
        b_load = 1'b0; b_din = 3'd0; b_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: en ignored while parked.
        repeat (5) step(0, 0, 3'd0, 1, 3'd0, 0, 0, 0);

        // Load 5, count through the wrap.
        step(0, 1, 3'd5, 0, 3'd5, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd6, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd7, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd0, !ONESHOT, 1, 0);
        step(0, 0, 3'd0, 1, ONESHOT ? 3'd0 : 3'd1, !ONESHOT, 0, 0);

        // Load 2, en pattern 1,0,0,1.
        step(0, 1, 3'd2, 0, 3'd2, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd3, 1, 0, 0);
        step(0, 0, 3'd0, 0, 3'd3, 1, 0, 0);
        step(0, 0, 3'd0, 0, 3'd3, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd4, 1, 0, 0);

        // Reload mid-run beats en; load with en=1 also ignores en.
        step(0, 1, 3'd6, 1, 3'd6, 1, 0, 0);
        step(0, 1, 3'd3, 1, 3'd3, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd4, 1, 0, 0);

        // Asynchronous reset between edges at count 4.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_count",  32'(a_count),  32'd0);
        chk("async_rst_active", 32'(a_active), 32'd0);
        chk("async_rst_carry",  32'(a_carry),  32'd0);
        a_load = 1'b0; a_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 3'd0, 1, 3'd0, 0, 0, 0);

        // Load 6 with en=1: 6,7,0 then parked (oneshot) or keeps running.
        step(0, 1, 3'd6, 1, 3'd6, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd7, 1, 0, 0);
        step(0, 0, 3'd0, 1, 3'd0, !ONESHOT, 1, 0);
        step(0, 0, 3'd0, 1, ONESHOT ? 3'd0 : 3'd1, !ONESHOT, 0, 0);
        step(0, 0, 3'd0, 1, ONESHOT ? 3'd0 : 3'd2, !ONESHOT, 0, 0);

        // LIMIT=5 instance: reject din=6, then load 4 and wrap.
        step(1, 1, 3'd6, 0, 3'd0, 0, 0, 1);
        step(1, 0, 3'd0, 1, 3'd0, 0, 0, 0);
        step(1, 1, 3'd4, 1, 3'd4, 1, 0, 0);
        step(1, 0, 3'd0, 1, 3'd5, 1, 0, 0);
        step(1, 0, 3'd0, 1, 3'd0, !ONESHOT, 1, 0);
        step(1, 0, 3'd0, 1, ONESHOT ? 3'd0 : 3'd1, !ONESHOT, 0, 0);

        // Rejected load while running parks it; load of exactly LIMIT accepted.
        step(1, 1, 3'd7, 1, 3'd0, 0, 0, 1);
        step(1, 0, 3'd0, 1, 3'd0, 0, 0, 0);
        step(1, 1, 3'd5, 0, 3'd5, 1, 0, 0);
        step(1, 0, 3'd0, 1, 3'd0, !ONESHOT, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
